// File: rtl/sweep_scheduler_pkg.sv
// sweep_scheduler_pkg: shared state encodings, parameter defaults and helpers for the solve sequencer
package sweep_scheduler_pkg;
  localparam int N_DEF          = 9;
  localparam int CW_DEF         = 4;
  localparam int MAX_PASSES_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT     = 3'd2,
    S_ADVANCE  = 3'd3,
    S_PASS_CHK = 3'd4,
    S_FINISH   = 3'd5
  } state_t;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/sweep_scheduler_if.sv
// sweep_scheduler_if: load control, datapath handshake and result signals of the solve sequencer
interface sweep_scheduler_if #(parameter int CW = 4);
  logic          load;
  logic          dp_done;
  logic          dp_changed;
  logic          dp_error;
  logic          dp_filled;
  logic          dp_start;
  logic [CW-1:0] cell_row;
  logic [CW-1:0] cell_col;
  logic          busy;
  logic          done;
  logic          solved;
  logic          stuck;
  logic          error;
  logic [7:0]    pass_count;
  logic [2:0]    state;
  modport slave (
    input  load, dp_done, dp_changed, dp_error, dp_filled,
    output dp_start, cell_row, cell_col, busy, done, solved, stuck, error, pass_count, state
  );
  modport master (
    output load, dp_done, dp_changed, dp_error, dp_filled,
    input  dp_start, cell_row, cell_col, busy, done, solved, stuck, error, pass_count, state
  );
endinterface

// File: rtl/sweep_scheduler_cell_cursor.sv
// sweep_scheduler_cell_cursor: row-major cell cursor with clear, step and last-cell flag
module sweep_scheduler_cell_cursor #(
  parameter int N  = 9,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);
  logic [CW-1:0] r_row, r_col;
  logic w_col_end, w_row_end;
  assign w_col_end = r_col == CW'(N - 1);
  assign w_row_end = r_row == CW'(N - 1);
  assign o_last    = w_col_end && w_row_end;
  assign o_row     = r_row;
  assign o_col     = r_col;
  // step walks columns then rows and parks on the final cell
  always_ff @(posedge clk)
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_step && !o_last) begin
      r_col <= w_col_end ? '0 : r_col + CW'(1);
      r_row <= w_col_end ? r_row + CW'(1) : r_row;
    end
endmodule

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: walks the grid issuing one datapath start per cell, repeating passes until a result
module sweep_scheduler import sweep_scheduler_pkg::*; #(
  parameter int N          = N_DEF,
  parameter int CW         = CW_DEF,
  parameter int MAX_PASSES = MAX_PASSES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic              clka,
  input logic              restart,
  sweep_scheduler_if.slave bus
);
  state_t        r_state;
  logic [7:0]    r_pass, r_timer, w_pass_next;
  logic          r_changed, r_solved, r_stuck, r_error;
  logic          w_clr, w_step, w_last, w_more;
  logic [CW-1:0] w_row, w_col;
  assign w_pass_next = sat_inc8(r_pass);
  assign w_more      = !bus.dp_filled && r_changed && (w_pass_next != 8'(MAX_PASSES));
  assign w_clr       = (r_state == S_IDLE && bus.load) || (r_state == S_PASS_CHK && w_more);
  assign w_step      = r_state == S_ADVANCE;
  sweep_scheduler_cell_cursor #(.N(N), .CW(CW)) u_cursor (
    .clk    (clka),
    .rst    (restart),
    .i_clr  (w_clr),
    .i_step (w_step),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last)
  );
  assign bus.dp_start   = r_state == S_ISSUE;
  assign bus.busy       = (r_state != S_IDLE) && (r_state <= S_FINISH);
  assign bus.done       = r_state == S_FINISH;
  assign bus.cell_row   = w_row;
  assign bus.cell_col   = w_col;
  assign bus.solved     = r_solved;
  assign bus.stuck      = r_stuck;
  assign bus.error      = r_error;
  assign bus.pass_count = r_pass;
  assign bus.state      = r_state;
  // sequencing FSM: per-cell handshake with timeout, pass bookkeeping and sticky result flags
  always_ff @(posedge clka)
    if (restart) begin
      r_state   <= S_IDLE;
      r_pass    <= '0;
      r_timer   <= '0;
      r_changed <= 1'b0;
      r_solved  <= 1'b0;
      r_stuck   <= 1'b0;
      r_error   <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (bus.load) begin
            r_pass    <= '0;
            r_changed <= 1'b0;
            r_solved  <= 1'b0;
            r_stuck   <= 1'b0;
            r_error   <= 1'b0;
            r_state   <= S_ISSUE;
          end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT:
          if (bus.dp_done) begin
            r_changed <= r_changed | bus.dp_changed;
            r_error   <= r_error | bus.dp_error;
            r_state   <= bus.dp_error ? S_FINISH : S_ADVANCE;
          end else begin
            r_timer <= r_timer + 8'd1;
            r_error <= r_error | (r_timer == 8'(TIMEOUT - 1));
            r_state <= (r_timer == 8'(TIMEOUT - 1)) ? S_FINISH : S_WAIT;
          end
        S_ADVANCE: r_state <= w_last ? S_PASS_CHK : S_ISSUE;
        S_PASS_CHK: begin
          r_pass    <= w_pass_next;
          r_solved  <= bus.dp_filled;
          r_stuck   <= !bus.dp_filled && !w_more;
          r_changed <= 1'b0;
          r_state   <= w_more ? S_ISSUE : S_FINISH;
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_sweep_scheduler.sv
// tb_sweep_scheduler: directed scenarios against a modelled cell datapath
module tb_sweep_scheduler;
  import sweep_scheduler_pkg::*;
  localparam int N = 9, CW = 4, MAXP = 32, TO = 255;
  logic clka = 1'b0;
  logic restart = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  int lat = 2, hang_r = -1, hang_c = -1, err_r = -1, err_c = -1, sp_r = -1, sp_c = -1, sp_lat = 0;
  int chg_upto = 0, fill_at = 0;
  int n_starts = 0, n_done = 0, cnt = 0, hang_cyc = 0;
  logic cur_err = 1'b0, cur_chg = 1'b0;
  sweep_scheduler_if #(.CW(CW)) bus();
  sweep_scheduler #(.N(N), .CW(CW), .MAX_PASSES(MAXP), .TIMEOUT(TO)) dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus)
  );
  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;
  // datapath model: answers each start after a configurable number of WAIT cycles
  always @(negedge clka) begin
    bus.dp_done = 1'b0;
    bus.dp_error = 1'b0;
    bus.dp_changed = 1'b0;
    if (bus.dp_start === 1'b1) begin
      n_starts++;
      cur_err = int'(bus.cell_row) == err_r && int'(bus.cell_col) == err_c;
      cur_chg = n_starts <= chg_upto;
      if (int'(bus.cell_row) == hang_r && int'(bus.cell_col) == hang_c) begin
        cnt = 0;
        hang_cyc = cyc;
      end else if (int'(bus.cell_row) == sp_r && int'(bus.cell_col) == sp_c) cnt = sp_lat;
      else cnt = lat;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bus.dp_done = 1'b1;
        bus.dp_error = cur_err;
        bus.dp_changed = cur_chg;
      end
    end
    bus.dp_filled = fill_at != 0 && n_starts >= fill_at;
    if (bus.done === 1'b1) n_done++;
  end
  task automatic step();
    @(negedge clka);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = bus.state == st;
    end
  endtask
  task automatic pulse_load(output int l);
    l = cyc;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask
  task automatic test_reset();
    int l;
    bit ok;
    bus.load = 1'b0;
    repeat (2) step();
    tests++; if (bus.state !== 3'd0) begin fails++; $display("FAIL reset state: got %0d want 0", bus.state); end
    tests++; if ({bus.dp_start, bus.busy, bus.done} !== 3'b000) begin fails++; $display("FAIL reset start/busy/done: got %b want 000", {bus.dp_start, bus.busy, bus.done}); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b000) begin fails++; $display("FAIL reset flags: got %b want 000", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (bus.pass_count !== 8'd0 || bus.cell_row !== 4'd0 || bus.cell_col !== 4'd0) begin fails++; $display("FAIL reset counters: pass %0d row %0d col %0d want 0 0 0", bus.pass_count, bus.cell_row, bus.cell_col); end
    lat = 2; chg_upto = n_starts + 81; fill_at = n_starts + 1;
    restart = 1'b0;
    pulse_load(l);
    tests++; if (bus.dp_start !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL first start: dp_start %b busy %b want 1 1", bus.dp_start, bus.busy); end
    tests++; if (bus.cell_row !== 4'd0 || bus.cell_col !== 4'd0) begin fails++; $display("FAIL first cell: row %0d col %0d want 0 0", bus.cell_row, bus.cell_col); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b000) begin fails++; $display("FAIL first flags: got %b want 000", {bus.solved, bus.stuck, bus.error}); end
    wait_state(S_FINISH, 1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL reset run finish: got timeout want FINISH"); end
    step();
    fill_at = 0;
  endtask
  task automatic test_stuck();
    int l, s0, d0;
    bit ok;
    s0 = n_starts; d0 = n_done;
    lat = 2; chg_upto = s0 + 81; fill_at = 0;
    pulse_load(l);
    wait_state(S_FINISH, 2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stuck finish: got timeout want FINISH"); end
    tests++; if (cyc !== l + 651) begin fails++; $display("FAIL stuck latency: got cycle %0d want %0d", cyc - l, 651); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b010) begin fails++; $display("FAIL stuck flags: got %b want 010", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (bus.pass_count !== 8'd2) begin fails++; $display("FAIL stuck pass_count: got %0d want 2", bus.pass_count); end
    tests++; if (n_starts - s0 !== 162) begin fails++; $display("FAIL stuck starts: got %0d want 162", n_starts - s0); end
    tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL stuck done/busy: got %b%b want 11", bus.done, bus.busy); end
    tests++; if (bus.cell_row !== 4'd8 || bus.cell_col !== 4'd8) begin fails++; $display("FAIL stuck cursor hold: row %0d col %0d want 8 8", bus.cell_row, bus.cell_col); end
    step();
    tests++; if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.stuck !== 1'b1 || bus.pass_count !== 8'd2) begin fails++; $display("FAIL stuck after: state %0d busy %b stuck %b pass %0d want 0 0 1 2", bus.state, bus.busy, bus.stuck, bus.pass_count); end
    tests++; if (n_done - d0 !== 1) begin fails++; $display("FAIL stuck done count: got %0d want 1", n_done - d0); end
  endtask
  task automatic test_solved();
    int l, s0, d0;
    bit ok;
    s0 = n_starts; d0 = n_done;
    lat = 2; chg_upto = s0 + 1000; fill_at = s0 + 40;
    pulse_load(l);
    tests++; if (bus.stuck !== 1'b0) begin fails++; $display("FAIL solved flag clear on load: stuck %b want 0", bus.stuck); end
    wait_state(S_FINISH, 1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL solved finish: got timeout want FINISH"); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b100) begin fails++; $display("FAIL solved flags: got %b want 100", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (bus.pass_count !== 8'd1) begin fails++; $display("FAIL solved pass_count: got %0d want 1", bus.pass_count); end
    tests++; if (n_starts - s0 !== 81) begin fails++; $display("FAIL solved starts: got %0d want 81", n_starts - s0); end
    repeat (3) step();
    tests++; if (n_done - d0 !== 1) begin fails++; $display("FAIL solved done count: got %0d want 1", n_done - d0); end
    fill_at = 0;
  endtask
  task automatic test_timeout();
    int l;
    bit ok;
    lat = 2; chg_upto = n_starts + 1000; hang_r = 0; hang_c = 3;
    pulse_load(l);
    wait_state(S_FINISH, 600, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout finish: got timeout want FINISH"); end
    tests++; if (cyc - hang_cyc !== TO + 1) begin fails++; $display("FAIL timeout latency: got %0d want %0d", cyc - hang_cyc, TO + 1); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b001) begin fails++; $display("FAIL timeout flags: got %b want 001", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (bus.cell_row !== 4'd0 || bus.cell_col !== 4'd3) begin fails++; $display("FAIL timeout cursor: row %0d col %0d want 0 3", bus.cell_row, bus.cell_col); end
    step();
    hang_r = -1; hang_c = -1;
  endtask
  task automatic test_dp_error();
    int l, s0;
    bit ok;
    s0 = n_starts;
    lat = 2; chg_upto = s0 + 1000; err_r = 4; err_c = 4;
    pulse_load(l);
    wait_state(S_FINISH, 600, ok);
    tests++; if (!ok) begin fails++; $display("FAIL dp_error finish: got timeout want FINISH"); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b001) begin fails++; $display("FAIL dp_error flags: got %b want 001", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (bus.cell_row !== 4'd4 || bus.cell_col !== 4'd4 || n_starts - s0 !== 41) begin fails++; $display("FAIL dp_error cell: row %0d col %0d starts %0d want 4 4 41", bus.cell_row, bus.cell_col, n_starts - s0); end
    step();
    err_r = -1; err_c = -1;
    s0 = n_starts;
    chg_upto = s0 + 1000; fill_at = s0 + 1; sp_r = 0; sp_c = 1; sp_lat = TO;
    pulse_load(l);
    wait_state(S_FINISH, 1500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL done-wins finish: got timeout want FINISH"); end
    tests++; if ({bus.solved, bus.stuck, bus.error} !== 3'b100) begin fails++; $display("FAIL done-wins flags: got %b want 100", {bus.solved, bus.stuck, bus.error}); end
    tests++; if (n_starts - s0 !== 81 || bus.pass_count !== 8'd1) begin fails++; $display("FAIL done-wins progress: starts %0d pass %0d want 81 1", n_starts - s0, bus.pass_count); end
    step();
    fill_at = 0; sp_r = -1; sp_c = -1;
  endtask
  task automatic test_restart_mid_run();
    int l, s0, d0;
    bit ok;
    s0 = n_starts; d0 = n_done;
    lat = 2; chg_upto = s0 + 1000; hang_r = 2; hang_c = 5;
    pulse_load(l);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = n_starts - s0 >= 10;
    end
    pulse_load(l);
    tests++; if (bus.state === 3'd0 || bus.cell_row !== 4'd1) begin fails++; $display("FAIL mid-run load: state %0d row %0d want non-idle row 1", bus.state, bus.cell_row); end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      ok = bus.state == S_WAIT && bus.cell_row == 4'd2 && bus.cell_col == 4'd5;
    end
    tests++; if (!ok || n_starts - s0 !== 24) begin fails++; $display("FAIL reach (2,5): reached %b starts %0d want 1 24", ok, n_starts - s0); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    tests++; if (bus.state !== 3'd0 || bus.dp_start !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL restart abort: state %0d start %b busy %b want 0 0 0", bus.state, bus.dp_start, bus.busy); end
    tests++; if (bus.cell_row !== 4'd0 || bus.cell_col !== 4'd0 || bus.error !== 1'b0) begin fails++; $display("FAIL restart cursor: row %0d col %0d error %b want 0 0 0", bus.cell_row, bus.cell_col, bus.error); end
    repeat (3) step();
    tests++; if (n_done - d0 !== 0 || bus.state !== 3'd0) begin fails++; $display("FAIL restart no done: done %0d state %0d want 0 0", n_done - d0, bus.state); end
    hang_r = -1; hang_c = -1;
  endtask
  initial begin
    bus.load = 1'b0;
    test_reset();
    test_stuck();
    test_solved();
    test_timeout();
    test_dp_error();
    test_restart_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
